// File: rtl/rgmii_rx_frame_parser_if.sv
// Receive-side bus of rgmii_rx_frame_parser: RGMII byte/qualifier inputs,
// payload stream with start/end markers, per-frame status and frame counters.
interface rgmii_rx_frame_parser_if #(
  parameter int CNT_W = 16
);
  logic [7:0]       rxDataIn;
  logic             rxDvIn;
  logic             rxErIn;
  logic [7:0]       dataOut;
  logic             validOut;
  logic             sofOut;
  logic             eofOut;
  logic             fcsErrOut;
  logic             runtErrOut;
  logic             giantErrOut;
  logic             phyErrOut;
  logic [CNT_W-1:0] goodCntOut;
  logic [CNT_W-1:0] badCntOut;

  modport master (
    output rxDataIn, rxDvIn, rxErIn,
    input  dataOut, validOut, sofOut, eofOut,
    input  fcsErrOut, runtErrOut, giantErrOut, phyErrOut,
    input  goodCntOut, badCntOut
  );

  modport slave (
    input  rxDataIn, rxDvIn, rxErIn,
    output dataOut, validOut, sofOut, eofOut,
    output fcsErrOut, runtErrOut, giantErrOut, phyErrOut,
    output goodCntOut, badCntOut
  );
endinterface

// File: rtl/rgmii_rx_frame_parser.sv
// RGMII receive framer: strips preamble/SFD, withholds FCS, length/PHY checks, CRC-32 when RX_FCS_CHECK_EN.
// Latency: byte sampled on edge n is on dataOut after edge n+5; eof after the edge that sees rxDvIn=0.
// Backpressure: none; at most one byte per clock, no gaps inside a frame.
module rgmii_rx_frame_parser #(
  parameter int MIN_FRAME = 64,
  parameter int MAX_FRAME = 1518,
  parameter int CNT_W     = 16
) (
  input logic                    rxClkIn,
  input logic                    rstIn,
  rgmii_rx_frame_parser_if.slave bus
);

  localparam logic [7:0]       PRE_BYTE = 8'h55;
  localparam logic [7:0]       SFD_BYTE = 8'hD5;
  localparam logic [10:0]      MIN_LEN  = 11'(MIN_FRAME);
  localparam logic [10:0]      MAX_LEN  = 11'(MAX_FRAME);
  localparam logic [10:0]      LEN_SAT  = 11'h7FF;
  localparam logic [CNT_W-1:0] CNT_SAT  = '1;

  typedef enum logic [1:0] {IDLE, PREAMBLE, PAYLOAD, DISCARD} state_t;

  state_t           state;
  state_t           stateNext;

  logic [7:0]       rxData;
  logic             rxDv;
  logic             rxEr;

  logic [7:0]       dly [5];
  logic [2:0]       fill;
  logic [10:0]      lenCnt;
  logic             emitted;
  logic             phyErr;
  logic             crcBad;

  logic             lineFull;
  logic             payByte;
  logic             startFrame;

  logic [7:0]       dataNext;
  logic             validNext;
  logic             sofNext;
  logic             eofNext;
  logic             fcsNext;
  logic             runtNext;
  logic             giantNext;
  logic             phyNext;
  logic             goodInc;
  logic             badInc;

  logic [7:0]       dataQ;
  logic             validQ;
  logic             sofQ;
  logic             eofQ;
  logic             fcsQ;
  logic             runtQ;
  logic             giantQ;
  logic             phyQ;
  logic [CNT_W-1:0] goodCnt;
  logic [CNT_W-1:0] badCnt;

  assign rxData     = bus.rxDataIn;
  assign rxDv       = bus.rxDvIn;
  assign rxEr       = bus.rxErIn;

  assign lineFull   = (fill == 3'd5);
  assign payByte    = (state == PAYLOAD) && rxDv;
  assign startFrame = rxDv && (rxData == SFD_BYTE) &&
                      ((state == IDLE) || (state == PREAMBLE));

  always_ff @(posedge rxClkIn) begin
    if (rstIn) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (rxDv) begin
          if (rxData == PRE_BYTE)      stateNext = PREAMBLE;
          else if (rxData == SFD_BYTE) stateNext = PAYLOAD;
          else                         stateNext = DISCARD;
        end
      end
      PREAMBLE: begin
        if (!rxDv)                   stateNext = IDLE;
        else if (rxData == SFD_BYTE) stateNext = PAYLOAD;
        else if (rxData != PRE_BYTE) stateNext = DISCARD;
      end
      PAYLOAD: begin
        if (!rxDv) stateNext = IDLE;
      end
      DISCARD: begin
        if (!rxDv) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // The oldest slot of a full line is the last payload byte once rxDvIn drops;
  // the four younger slots hold the FCS and are simply abandoned.
  always_comb begin
    dataNext  = '0;
    validNext = 1'b0;
    sofNext   = 1'b0;
    eofNext   = 1'b0;
    fcsNext   = 1'b0;
    runtNext  = 1'b0;
    giantNext = 1'b0;
    phyNext   = 1'b0;
    goodInc   = 1'b0;
    badInc    = 1'b0;
    case (state)
      PAYLOAD: begin
        if (rxDv) begin
          if (lineFull) begin
            validNext = 1'b1;
            sofNext   = !emitted;
            dataNext  = dly[4];
          end
        end else begin
          eofNext   = 1'b1;
          validNext = lineFull;
          sofNext   = lineFull && !emitted;
          dataNext  = lineFull ? dly[4] : 8'h00;
          runtNext  = (lenCnt < MIN_LEN);
          giantNext = (lenCnt > MAX_LEN);
          phyNext   = phyErr;
          fcsNext   = crcBad;
          goodInc   = !(runtNext || giantNext || phyNext || fcsNext);
          badInc    = !goodInc;
        end
      end
      DISCARD: begin
        badInc = !rxDv;
      end
      default: ;
    endcase
  end

  always_ff @(posedge rxClkIn) begin
    if (rstIn) begin
      for (int i = 0; i < 5; i++) dly[i] <= '0;
      fill    <= '0;
      lenCnt  <= '0;
      emitted <= 1'b0;
      phyErr  <= 1'b0;
    end else if (startFrame) begin
      fill    <= '0;
      lenCnt  <= '0;
      emitted <= 1'b0;
      phyErr  <= 1'b0;
    end else if (payByte) begin
      for (int i = 4; i > 0; i--) dly[i] <= dly[i-1];
      dly[0] <= rxData;
      if (!lineFull)         fill    <= fill + 3'd1;
      if (lenCnt != LEN_SAT) lenCnt  <= lenCnt + 11'd1;
      if (lineFull)          emitted <= 1'b1;
      if (rxEr)              phyErr  <= 1'b1;
    end
  end

`ifdef RX_FCS_CHECK_EN
  logic [31:0] crc;

  function automatic logic [31:0] crcByte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int b = 0; b < 8; b++) begin
      if (r[0] ^ d[b]) r = (r >> 1) ^ 32'hEDB88320;
      else             r = r >> 1;
    end
    return r;
  endfunction

  // Running the CRC across the received FCS too leaves the fixed residue on a good frame.
  assign crcBad = (crc != 32'hDEBB20E3);

  always_ff @(posedge rxClkIn) begin
    if (rstIn || startFrame) begin
      crc <= 32'hFFFFFFFF;
    end else if (payByte) begin
      crc <= crcByte(crc, rxData);
    end
  end
`else
  assign crcBad = 1'b0;
`endif

  always_ff @(posedge rxClkIn) begin
    if (rstIn) begin
      dataQ   <= '0;
      validQ  <= 1'b0;
      sofQ    <= 1'b0;
      eofQ    <= 1'b0;
      fcsQ    <= 1'b0;
      runtQ   <= 1'b0;
      giantQ  <= 1'b0;
      phyQ    <= 1'b0;
      goodCnt <= '0;
      badCnt  <= '0;
    end else begin
      dataQ  <= dataNext;
      validQ <= validNext;
      sofQ   <= sofNext;
      eofQ   <= eofNext;
      fcsQ   <= fcsNext;
      runtQ  <= runtNext;
      giantQ <= giantNext;
      phyQ   <= phyNext;
      if (goodInc && (goodCnt != CNT_SAT)) goodCnt <= goodCnt + 1'b1;
      if (badInc  && (badCnt  != CNT_SAT)) badCnt  <= badCnt + 1'b1;
    end
  end

  assign bus.dataOut     = dataQ;
  assign bus.validOut    = validQ;
  assign bus.sofOut      = sofQ;
  assign bus.eofOut      = eofQ;
  assign bus.fcsErrOut   = fcsQ;
  assign bus.runtErrOut  = runtQ;
  assign bus.giantErrOut = giantQ;
  assign bus.phyErrOut   = phyQ;
  assign bus.goodCntOut  = goodCnt;
  assign bus.badCntOut   = badCnt;

endmodule

// File: tb/tb_rgmii_rx_frame_parser.sv
// Scoreboard bench for rgmii_rx_frame_parser: frames driven byte by byte,
// expected output bytes/status queued at drive time and checked as the DUT emits them.
module tb_rgmii_rx_frame_parser;

  logic rxClkIn = 1'b0;
  logic rstIn;

  always #4 rxClkIn = ~rxClkIn;

  rgmii_rx_frame_parser_if #(.CNT_W(16)) bus();

  rgmii_rx_frame_parser #(
    .MIN_FRAME(64),
    .MAX_FRAME(1518),
    .CNT_W(16)
  ) dut (
    .rxClkIn(rxClkIn),
    .rstIn(rstIn),
    .bus(bus)
  );

  typedef struct {
    logic [7:0] d;
    logic       v, sof, eof, fcs, runt, giant, phy;
    int         cyc;
  } exp_t;

  exp_t        expQ[$];
  exp_t        mon;
  logic [7:0]  frm[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  logic [15:0] expGood = '0;
  logic [15:0] expBad = '0;
  logic [14:0] obsV, expV;

  always @(posedge rxClkIn) cyc <= cyc + 1;

  always @(negedge rxClkIn) begin
    if (bus.validOut || bus.eofOut) begin
      if (expQ.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL spurious_output cyc=%0d got data=%02h valid=%b eof=%b, wanted nothing",
                 cyc, bus.dataOut, bus.validOut, bus.eofOut);
      end else begin
        mon  = expQ.pop_front();
        obsV = {bus.validOut, bus.sofOut, bus.eofOut, bus.fcsErrOut, bus.runtErrOut,
                bus.giantErrOut, bus.phyErrOut, (bus.validOut ? bus.dataOut : 8'h00)};
        expV = {mon.v, mon.sof, mon.eof, mon.fcs, mon.runt, mon.giant, mon.phy,
                (mon.v ? mon.d : 8'h00)};
        vectors++;
        if (obsV !== expV) begin
          miscompares++;
          $display("FAIL out_word cyc=%0d got v/sof/eof/fcs/runt/giant/phy/data=%b required %b",
                   cyc, obsV, expV);
        end
        vectors++;
        if (cyc !== mon.cyc) begin
          miscompares++;
          $display("FAIL out_latency got cycle %0d required %0d", cyc, mon.cyc);
        end
      end
    end
  end

  task automatic putByte(input logic dv, input logic er, input logic [7:0] d);
    @(posedge rxClkIn);
    #1;
    bus.rxDvIn   = dv;
    bus.rxErIn   = er;
    bus.rxDataIn = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) putByte(1'b0, 1'b0, 8'h00);
  endtask

  function automatic logic [31:0] crcOf(input int n);
    logic [31:0] r;
    r = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      for (int b = 0; b < 8; b++) begin
        if (r[0] ^ frm[i][b]) r = (r >> 1) ^ 32'hEDB88320;
        else                  r = r >> 1;
      end
    end
    return r;
  endfunction

  // Payload of payLen bytes (counting or random) followed by its little-endian FCS.
  task automatic buildFrame(input int payLen, input bit randomData, input bit corrupt);
    logic [31:0] fcs;
    frm.delete();
    for (int i = 0; i < payLen; i++) frm.push_back(randomData ? 8'($urandom) : 8'(i));
    fcs = ~crcOf(payLen);
    frm.push_back(fcs[7:0]);
    frm.push_back(fcs[15:8]);
    frm.push_back(fcs[23:16]);
    frm.push_back(fcs[31:24]);
    if (corrupt) frm[payLen][0] = ~frm[payLen][0];
  endtask

  task automatic sendFrame(input int nPre, input int erAt, input bit fcsBad);
    exp_t e;
    int   n;
    logic runt, giant, phy, fcs;
    n     = frm.size();
    runt  = (n < 64);
    giant = (n > 1518);
    phy   = (erAt >= 0) && (erAt < n);
`ifdef RX_FCS_CHECK_EN
    fcs   = fcsBad;
`else
    fcs   = 1'b0;
`endif
    for (int p = 0; p < nPre; p++) putByte(1'b1, 1'b0, 8'h55);
    putByte(1'b1, 1'b0, 8'hD5);
    for (int i = 0; i < n; i++) begin
      putByte(1'b1, (i == erAt), frm[i]);
      if (i <= n - 5) begin
        e = '{d: frm[i], v: 1'b1, sof: (i == 0), eof: (i == n - 5),
              fcs: 1'b0, runt: 1'b0, giant: 1'b0, phy: 1'b0, cyc: cyc + 6};
        if (e.eof) begin
          e.fcs = fcs; e.runt = runt; e.giant = giant; e.phy = phy;
        end
        expQ.push_back(e);
      end
    end
    putByte(1'b0, 1'b0, 8'h00);
    if (n < 5) begin
      e = '{d: 8'h00, v: 1'b0, sof: 1'b0, eof: 1'b1,
            fcs: fcs, runt: runt, giant: giant, phy: phy, cyc: cyc + 1};
      expQ.push_back(e);
    end
    if (runt || giant || phy || fcs) expBad++;
    else                             expGood++;
  endtask

  task automatic test_counters(input string tag);
    idle(8);
    vectors++;
    if (bus.goodCntOut !== expGood) begin
      miscompares++;
      $display("FAIL %s good_cnt got %0d required %0d", tag, bus.goodCntOut, expGood);
    end
    vectors++;
    if (bus.badCntOut !== expBad) begin
      miscompares++;
      $display("FAIL %s bad_cnt got %0d required %0d", tag, bus.badCntOut, expBad);
    end
  endtask

  task automatic test_reset();
    rstIn        = 1'b1;
    bus.rxDvIn   = 1'b0;
    bus.rxErIn   = 1'b0;
    bus.rxDataIn = 8'h00;
    repeat (3) @(posedge rxClkIn);
    @(negedge rxClkIn);
    vectors++;
    if ({bus.dataOut, bus.validOut, bus.sofOut, bus.eofOut, bus.fcsErrOut, bus.runtErrOut,
         bus.giantErrOut, bus.phyErrOut, bus.goodCntOut, bus.badCntOut} !== 47'd0) begin
      miscompares++;
      $display("FAIL reset_outputs got data=%02h v=%b good=%0d bad=%0d required all zero",
               bus.dataOut, bus.validOut, bus.goodCntOut, bus.badCntOut);
    end
    @(posedge rxClkIn);
    #1 rstIn = 1'b0;
  endtask

  task automatic test_good_frame();
    buildFrame(60, 1'b0, 1'b0);
    sendFrame(7, -1, 1'b0);
    test_counters("good_frame");
  endtask

  task automatic test_bad_fcs();
    buildFrame(60, 1'b0, 1'b1);
    sendFrame(7, -1, 1'b1);
    test_counters("bad_fcs");
  endtask

  task automatic test_runt();
    buildFrame(16, 1'b1, 1'b0);
    sendFrame(7, -1, 1'b0);
    test_counters("runt20");
    frm.delete();
    frm.push_back(8'h11);
    frm.push_back(8'h22);
    frm.push_back(8'h33);
    sendFrame(7, -1, 1'b1);
    test_counters("runt3");
  endtask

  task automatic test_giant_phy();
    buildFrame(1596, 1'b1, 1'b0);
    sendFrame(7, -1, 1'b0);
    test_counters("giant");
    buildFrame(60, 1'b1, 1'b0);
    sendFrame(7, 30, 1'b0);
    test_counters("phy_err");
  endtask

  task automatic test_discard();
    putByte(1'b1, 1'b0, 8'h55);
    putByte(1'b1, 1'b0, 8'h55);
    putByte(1'b1, 1'b0, 8'h55);
    putByte(1'b1, 1'b0, 8'h12);
    for (int i = 0; i < 6; i++) putByte(1'b1, 1'b0, 8'hD5);
    putByte(1'b0, 1'b0, 8'h00);
    expBad++;
    test_counters("discard");
    putByte(1'b1, 1'b0, 8'h55);
    putByte(1'b1, 1'b0, 8'h55);
    putByte(1'b0, 1'b0, 8'h00);
    test_counters("preamble_abort");
    for (int i = 0; i < 5; i++) putByte(1'b0, 1'b1, 8'hD5);
    test_counters("false_carrier");
  endtask

  task automatic test_back_to_back();
    buildFrame(60, 1'b1, 1'b0);
    sendFrame(7, -1, 1'b0);
    buildFrame(70, 1'b1, 1'b0);
    sendFrame(0, -1, 1'b0);
    buildFrame(61, 1'b1, 1'b0);
    sendFrame(3, -1, 1'b0);
    test_counters("back_to_back");
  endtask

  task automatic test_mid_reset();
    exp_t e;
    for (int p = 0; p < 7; p++) putByte(1'b1, 1'b0, 8'h55);
    putByte(1'b1, 1'b0, 8'hD5);
    for (int i = 0; i < 10; i++) begin
      putByte(1'b1, 1'b0, 8'h20 + 8'(i));
      if (i < 5) begin
        e = '{d: 8'h20 + 8'(i), v: 1'b1, sof: (i == 0), eof: 1'b0,
              fcs: 1'b0, runt: 1'b0, giant: 1'b0, phy: 1'b0, cyc: cyc + 6};
        expQ.push_back(e);
      end
    end
    @(posedge rxClkIn);
    #1;
    rstIn        = 1'b1;
    bus.rxDataIn = 8'h2A;
    @(posedge rxClkIn);
    #1;
    rstIn        = 1'b0;
    bus.rxDataIn = 8'h2B;
    @(negedge rxClkIn);
    vectors++;
    if ({bus.dataOut, bus.validOut, bus.sofOut, bus.eofOut, bus.fcsErrOut, bus.runtErrOut,
         bus.giantErrOut, bus.phyErrOut, bus.goodCntOut, bus.badCntOut} !== 47'd0) begin
      miscompares++;
      $display("FAIL mid_reset_outputs got data=%02h v=%b eof=%b good=%0d bad=%0d required all zero",
               bus.dataOut, bus.validOut, bus.eofOut, bus.goodCntOut, bus.badCntOut);
    end
    for (int i = 12; i < 20; i++) putByte(1'b1, 1'b0, 8'h20 + 8'(i));
    putByte(1'b0, 1'b0, 8'h00);
    expGood = 16'd0;
    expBad  = 16'd1;
    test_counters("mid_reset_tail");
    buildFrame(60, 1'b1, 1'b0);
    sendFrame(7, -1, 1'b0);
    test_counters("after_reset");
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_fcs();
    test_runt();
    test_giant_phy();
    test_discard();
    test_back_to_back();
    test_mid_reset();
    idle(10);
    vectors++;
    if (expQ.size() != 0) begin
      miscompares++;
      $display("FAIL missing_output got %0d expected bytes never emitted, required 0", expQ.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
